// File: rtl/ps2_player_keys_if.sv
// PS/2 keyboard-to-host bus: clock and data lines driven by the keyboard.
interface ps2_player_keys_if;
    logic ps2_clk;
    logic ps2_data;

    modport master (output ps2_clk, output ps2_data);
    modport slave  (input  ps2_clk, input  ps2_data);
endinterface

// File: rtl/ps2_player_keys.sv
// PS/2 receiver and scan-code decoder producing held-key levels for two players
// (Z/Q/S/D for player 1, extended arrow keys for player 2).
module ps2_player_keys #(
    parameter int unsigned FILTER_LEN     = 4,
    parameter int unsigned TIMEOUT_CYCLES = 25000
) (
    input  logic                clk,
    input  logic                reset,
    ps2_player_keys_if.slave    ps2,
    output logic                j1_up,
    output logic                j1_down,
    output logic                j1_left,
    output logic                j1_right,
    output logic                j2_up,
    output logic                j2_down,
    output logic                j2_left,
    output logic                j2_right,
    output logic [7:0]          rx_byte,
    output logic                rx_valid,
    output logic                frame_err
);
    localparam int unsigned FILT_W = $clog2(FILTER_LEN + 1);
    localparam int unsigned TO_W   = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {ST_IDLE, ST_DATA, ST_PARITY, ST_STOP} state_t;

    logic [1:0]        sync_clk_q, sync_clk_d, sync_dat_q, sync_dat_d;
    logic              filt_q, filt_d, fall_q, fall_d;
    logic [FILT_W-1:0] filt_cnt_q, filt_cnt_d;
    state_t            state_q, state_d;
    logic [2:0]        bit_cnt_q, bit_cnt_d;
    logic [7:0]        shift_q, shift_d;
    logic              par_q, par_d;
    logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
    logic [7:0]        rx_byte_q, rx_byte_d;
    logic              rx_valid_q, rx_valid_d, frame_err_q, frame_err_d;
    logic              ext_q, ext_d, brk_q, brk_d;
    logic [7:0]        keys_q, keys_d;
    logic              clk_s, dat_s;

    assign clk_s = sync_clk_q[1];
    assign dat_s = sync_dat_q[1];

    always_comb begin
        sync_clk_d  = {sync_clk_q[0], ps2.ps2_clk};
        sync_dat_d  = {sync_dat_q[0], ps2.ps2_data};
        filt_d      = filt_q;
        filt_cnt_d  = '0;
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        par_d       = par_q;
        to_cnt_d    = to_cnt_q;
        rx_byte_d   = rx_byte_q;
        rx_valid_d  = 1'b0;
        frame_err_d = 1'b0;
        ext_d       = ext_q;
        brk_d       = brk_q;
        keys_d      = keys_q;

        // Glitch filter: flip only after FILTER_LEN consecutive differing samples
        if (clk_s != filt_q) begin
            if (filt_cnt_q == FILT_W'(FILTER_LEN - 1)) begin
                filt_d = clk_s;
            end else begin
                filt_cnt_d = filt_cnt_q + FILT_W'(1);
            end
        end
        fall_d = filt_q & ~filt_d;

        if (state_q == ST_IDLE || fall_q) begin
            to_cnt_d = '0;
        end else begin
            to_cnt_d = to_cnt_q + TO_W'(1);
        end

        case (state_q)
            ST_IDLE: begin
                if (fall_q && !dat_s) begin
                    state_d   = ST_DATA;
                    bit_cnt_d = 3'd0;
                end
            end
            ST_DATA: begin
                if (fall_q) begin
                    shift_d   = {dat_s, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = ST_PARITY;
                    end
                end
            end
            ST_PARITY: begin
                if (fall_q) begin
                    par_d   = dat_s;
                    state_d = ST_STOP;
                end
            end
            ST_STOP: begin
                if (fall_q) begin
                    if (dat_s && (^{par_q, shift_q})) begin
                        rx_valid_d = 1'b1;
                        rx_byte_d  = shift_q;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Stalled frame: drop it and report
        if (state_q != ST_IDLE && !fall_q &&
            to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
            state_d     = ST_IDLE;
            frame_err_d = 1'b1;
            to_cnt_d    = '0;
        end

        // Scan-code decoder; prefixes accumulate until a non-prefix byte
        if (frame_err_q) begin
            ext_d = 1'b0;
            brk_d = 1'b0;
        end else if (rx_valid_q) begin
            case (rx_byte_q)
                8'hE0:   ext_d = 1'b1;
                8'hF0:   brk_d = 1'b1;
                default: begin
                    case ({ext_q, rx_byte_q})
                        9'h01D:  keys_d[0] = ~brk_q;
                        9'h01B:  keys_d[1] = ~brk_q;
                        9'h01C:  keys_d[2] = ~brk_q;
                        9'h023:  keys_d[3] = ~brk_q;
                        9'h175:  keys_d[4] = ~brk_q;
                        9'h172:  keys_d[5] = ~brk_q;
                        9'h16B:  keys_d[6] = ~brk_q;
                        9'h174:  keys_d[7] = ~brk_q;
                        default: keys_d    = keys_q;
                    endcase
                    ext_d = 1'b0;
                    brk_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_clk_q  <= 2'b11;
            sync_dat_q  <= 2'b11;
            filt_q      <= 1'b1;
            filt_cnt_q  <= '0;
            fall_q      <= 1'b0;
            state_q     <= ST_IDLE;
            bit_cnt_q   <= 3'd0;
            shift_q     <= 8'h00;
            par_q       <= 1'b0;
            to_cnt_q    <= '0;
            rx_byte_q   <= 8'h00;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
            ext_q       <= 1'b0;
            brk_q       <= 1'b0;
            keys_q      <= 8'h00;
        end else begin
            sync_clk_q  <= sync_clk_d;
            sync_dat_q  <= sync_dat_d;
            filt_q      <= filt_d;
            filt_cnt_q  <= filt_cnt_d;
            fall_q      <= fall_d;
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            par_q       <= par_d;
            to_cnt_q    <= to_cnt_d;
            rx_byte_q   <= rx_byte_d;
            rx_valid_q  <= rx_valid_d;
            frame_err_q <= frame_err_d;
            ext_q       <= ext_d;
            brk_q       <= brk_d;
            keys_q      <= keys_d;
        end
    end

    assign j1_up     = keys_q[0];
    assign j1_down   = keys_q[1];
    assign j1_left   = keys_q[2];
    assign j1_right  = keys_q[3];
    assign j2_up     = keys_q[4];
    assign j2_down   = keys_q[5];
    assign j2_left   = keys_q[6];
    assign j2_right  = keys_q[7];
    assign rx_byte   = rx_byte_q;
    assign rx_valid  = rx_valid_q;
    assign frame_err = frame_err_q;
endmodule
